// File: rtl/vram_pkg.sv
// vram_pkg: shared widths and controller states for the VRAM controller
package vram_pkg;
  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 32;
  typedef enum logic [2:0] {IDLE, VRD, CRD, CWR, FIN} state_t;
endpackage

// File: rtl/vram_req_latch.sv
// vram_req_latch: captures a request strobe and its payload until the arbiter services it
module vram_req_latch
  import vram_pkg::*;
#(
  parameter int W = VRAM_AW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stb,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         nxt_pend,
  output logic [W-1:0] nxt
);
  logic         pend;
  logic         acc;
  logic [W-1:0] held;
  always_comb begin
    acc      = stb && (!pend || clr);
    nxt_pend = acc || (pend && !clr);
    nxt      = acc ? din : held;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
      held <= '0;
    end else begin
      pend <= nxt_pend;
      held <= nxt;
    end
  end
endmodule

// File: rtl/vram_ctrl.sv
// vram_ctrl: arbitrates CPU and scanout accesses onto a single-ported synchronous SRAM
module vram_ctrl
  import vram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  input  logic               cpu_req,
  input  logic               cpu_write,
  output logic [VRAM_DW-1:0] cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_done,
  output logic               cpu_busy,
  input  logic [VRAM_AW-1:0] vid_addr,
  input  logic               vid_req,
  output logic [VRAM_DW-1:0] vid_data,
  output logic               vid_ready,
  output logic [VRAM_AW-1:0] sram_a,
  output logic [VRAM_DW-1:0] sram_do,
  input  logic [VRAM_DW-1:0] sram_di,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);
  localparam int CW = 1 + VRAM_AW + VRAM_DW;
  state_t             state;
  logic [3:0]         cnt;
  logic               last_vid;
  logic               cv;
  logic               vv;
  logic               go;
  logic               pick_v;
  logic               cw;
  logic [CW-1:0]      cpu_nxt;
  logic [VRAM_AW-1:0] ca;
  logic [VRAM_AW-1:0] va;
  logic [VRAM_DW-1:0] cd;
  vram_req_latch #(.W(CW)) u_cpu (
    .clk      (clk),
    .reset    (reset),
    .stb      (cpu_req || cpu_write),
    .clr      (cpu_ready || cpu_done),
    .din      ({cpu_write, cpu_addr, cpu_wdata}),
    .nxt_pend (cv),
    .nxt      (cpu_nxt)
  );
  vram_req_latch #(.W(VRAM_AW)) u_vid (
    .clk      (clk),
    .reset    (reset),
    .stb      (vid_req),
    .clr      (vid_ready),
    .din      (vid_addr),
    .nxt_pend (vv),
    .nxt      (va)
  );
  always_comb begin
    {cw, ca, cd} = cpu_nxt;
    go           = (state == IDLE || state == FIN) && (cv || vv);
    pick_v       = vv && !(last_vid && cv);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_vid  <= 1'b0;
      sram_a    <= '0;
      sram_do   <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      cpu_ready <= 1'b0;
      cpu_done  <= 1'b0;
      vid_ready <= 1'b0;
      cpu_busy  <= 1'b0;
      cpu_rdata <= '0;
      vid_data  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_done  <= 1'b0;
      vid_ready <= 1'b0;
      cpu_busy  <= cv;
      if (go) begin
        cnt       <= 4'(ACCESS_CYCLES - 1);
        last_vid  <= pick_v;
        sram_ce_n <= 1'b0;
        sram_a    <= pick_v ? va : ca;
        if (pick_v) begin
          state     <= VRD;
          sram_oe_n <= 1'b0;
        end else if (cw) begin
          state     <= CWR;
          sram_do   <= cd;
          sram_we_n <= 1'b0;
        end else begin
          state     <= CRD;
          sram_oe_n <= 1'b0;
        end
      end else begin
        case (state)
          VRD, CRD, CWR: begin
            if (cnt == 4'd0) begin
              state     <= FIN;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_we_n <= 1'b1;
              vid_ready <= state == VRD;
              cpu_ready <= state == CRD;
              cpu_done  <= state == CWR;
              if (state == VRD) vid_data <= sram_di;
              if (state == CRD) cpu_rdata <= sram_di;
            end else begin
              cnt <= cnt - 4'd1;
              // the last write cycle holds address and data with the strobe released
              if (cnt == 4'd1) sram_we_n <= 1'b1;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vram_ctrl.sv
// tb_vram_ctrl: randomized self-checking bench for vram_ctrl against a transaction-level model
module tb_vram_ctrl;
  localparam int A = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [14:0] vid_addr = '0;
  logic [14:0] sram_a;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic [31:0] vid_data;
  logic [31:0] sram_do;
  logic [31:0] sram_di;
  logic        cpu_req = 1'b0;
  logic        cpu_write = 1'b0;
  logic        vid_req = 1'b0;
  logic        cpu_ready, cpu_done, cpu_busy, vid_ready;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cyc = -100;
  bit          follow = 1'b0;
  logic [31:0] ram [0:32767];
  logic [31:0] mem [int];
  bit          m_cp, m_cw, m_vp, m_act, m_lastv, e_vr;
  logic [14:0] m_ca, m_va, m_sa;
  logic [31:0] m_cd, m_sdo, m_rd, m_vd, m_q;
  int          m_start, m_fin, m_own;
  always #5 clk = ~clk;
  vram_ctrl #(.ACCESS_CYCLES(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_req   (cpu_req),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .vid_addr  (vid_addr),
    .vid_req   (vid_req),
    .vid_data  (vid_data),
    .vid_ready (vid_ready),
    .sram_a    (sram_a),
    .sram_do   (sram_do),
    .sram_di   (sram_di),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );
  assign sram_di = (!sram_ce_n && !sram_oe_n) ? ram[sram_a] : 32'hDEAD_0000;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) ram[sram_a] <= sram_do;
  function automatic logic [31:0] ival(input logic [14:0] a);
    return {a, 17'h0} ^ (32'(a) * 32'h9E37_79B1);
  endfunction
  function automatic logic [31:0] mrd(input logic [14:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : ival(a);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_cycle();
    bit acc, fin;
    acc = m_act && cyc >= m_start && cyc < m_fin;
    fin = m_act && cyc == m_fin;
    if (fin && m_own == 0) m_rd = m_q;
    if (fin && m_own == 2) m_vd = m_q;
    e_vr = fin && m_own == 2;
    chk("ce_n", 32'(sram_ce_n), 32'(!acc));
    chk("oe_n", 32'(sram_oe_n), 32'(!(acc && m_own != 1)));
    chk("we_n", 32'(sram_we_n), 32'(!(acc && m_own == 1 && cyc < m_fin - 1)));
    chk("cpu_ready", 32'(cpu_ready), 32'(fin && m_own == 0));
    chk("cpu_done", 32'(cpu_done), 32'(fin && m_own == 1));
    chk("vid_ready", 32'(vid_ready), 32'(e_vr));
    chk("cpu_busy", 32'(cpu_busy), 32'(m_cp));
    chk("sram_a", 32'(sram_a), 32'(m_sa));
    chk("sram_do", sram_do, m_sdo);
    chk("cpu_rdata", cpu_rdata, m_rd);
    chk("vid_data", vid_data, m_vd);
    if (cpu_done) done_cyc = cyc;
  endtask
  task automatic step(input bit r, input bit cr, input bit cw, input logic [14:0] ca,
                      input logic [31:0] cd, input bit vr0, input logic [14:0] va);
    bit clr_c, clr_v, usev, vr;
    @(negedge clk);
    check_cycle();
    vr        = vr0 || (follow && e_vr);
    reset     = r;
    cpu_req   = cr;
    cpu_write = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    vid_req   = vr;
    vid_addr  = va;
    if (!r) begin
      m_cp = 0; m_vp = 0; m_act = 0; m_lastv = 0;
      m_sa = '0; m_sdo = '0; m_rd = '0; m_vd = '0;
    end else begin
      clr_c = m_act && cyc == m_fin && m_own != 2;
      clr_v = m_act && cyc == m_fin && m_own == 2;
      if ((cr || cw) && (!m_cp || clr_c)) begin
        m_cp = 1; m_cw = cw; m_ca = ca; m_cd = cd;
      end else if (clr_c) m_cp = 0;
      if (vr && (!m_vp || clr_v)) begin
        m_vp = 1; m_va = va;
      end else if (clr_v) m_vp = 0;
      if (!m_act || cyc == m_fin) begin
        m_act = m_cp || m_vp;
        usev  = m_vp && !(m_lastv && m_cp);
        if (m_act) begin
          m_start = cyc + 1;
          m_fin   = cyc + 1 + A;
          m_lastv = usev;
          if (usev) begin
            m_own = 2; m_sa = m_va; m_q = mrd(m_va);
          end else if (m_cw) begin
            m_own = 1; m_sa = m_ca; m_sdo = m_cd; mem[int'(m_ca)] = m_cd;
          end else begin
            m_own = 0; m_sa = m_ca; m_q = mrd(m_ca);
          end
        end
      end
    end
    cyc++;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, '0, '0, 0, '0);
  endtask
  initial begin
    int ac;
    for (int i = 0; i < 32768; i++) ram[i] = ival(15'(i));
    m_cp = 0; m_vp = 0; m_act = 0; m_lastv = 0;
    m_sa = '0; m_sdo = '0; m_rd = '0; m_vd = '0; m_q = '0;
    @(posedge clk);
    repeat (3) step(0, 1, 1, 15'h7, 32'h1, 1, 15'h9);
    idle(3);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    step(1, 0, 1, 15'o12345, 32'o17777777777, 0, '0);
    idle(3);
    chk("wr_done", 32'(cpu_done), 32'd1);
    idle(3);
    step(1, 1, 0, 15'o12345, '0, 0, '0);
    idle(3);
    chk("rb_ready", 32'(cpu_ready), 32'd1);
    chk("rb_data", cpu_rdata, 32'o17777777777);
    idle(3);
    step(1, 1, 0, 15'd1, '0, 1, 15'd0);
    idle(3);
    chk("col_vready", 32'(vid_ready), 32'd1);
    chk("col_vdata", vid_data, ival(15'd0));
    idle(3);
    chk("col_cready", 32'(cpu_ready), 32'd1);
    chk("col_cdata", cpu_rdata, ival(15'd1));
    idle(3);
    follow = 1'b1;
    step(1, 0, 0, '0, '0, 1, 15'd100);
    ac = -1;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, i == 5, 15'd200, 32'hCAFE_0001, 0, 15'(101 + i));
      if (i == 5) ac = cyc - 1;
    end
    chk("starve_lat", 32'(done_cyc > ac && done_cyc - ac <= 6), 32'd1);
    follow = 1'b0;
    idle(8);
    step(1, 1, 0, 15'd3, '0, 0, '0);
    idle(1);
    step(0, 0, 0, '0, '0, 0, '0);
    step(1, 0, 0, '0, '0, 0, '0);
    chk("abort_ce", 32'(sram_ce_n), 32'd1);
    idle(6);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) != 0 ? 15'($urandom_range(0, 15)) : 15'($urandom),
           $urandom, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) != 0 ? 15'($urandom_range(0, 15)) : 15'($urandom));
    end
    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
